// File: rtl/iob_eth_bd_arbiter.sv
// iob_eth_bd_arbiter: arbitrates port B of the ethernet buffer-descriptor RAM
// between the DMA TX and RX descriptor engines. Grants are combinational
// (zero-wait), fair round-robin, with locked multi-access sequences and a
// watchdog that reclaims a lock from a hung owner.
// Optional build macro: IOB_ETH_BD_ARB_RX_PRIO_EN -- when defined, RX wins
// every tie while the port is unowned; otherwise ties alternate.
module iob_eth_bd_arbiter #(
    parameter int BD_ADDR_W  = 8,
    parameter int DATA_W     = 32,
    parameter int LOCK_MAX_W = 6
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cke_i,

    input  logic                 tx_req_i,
    input  logic [BD_ADDR_W-1:0] tx_addr_i,
    input  logic                 tx_wen_i,
    input  logic [DATA_W-1:0]    tx_wdata_i,
    input  logic                 tx_lock_i,
    output logic                 tx_ack_o,
    output logic                 tx_rvalid_o,
    output logic [DATA_W-1:0]    tx_rdata_o,

    input  logic                 rx_req_i,
    input  logic [BD_ADDR_W-1:0] rx_addr_i,
    input  logic                 rx_wen_i,
    input  logic [DATA_W-1:0]    rx_wdata_i,
    input  logic                 rx_lock_i,
    output logic                 rx_ack_o,
    output logic                 rx_rvalid_o,
    output logic [DATA_W-1:0]    rx_rdata_o,

    output logic                 bd_en_o,
    output logic [BD_ADDR_W-1:0] bd_addr_o,
    output logic                 bd_wen_o,
    output logic [DATA_W-1:0]    bd_o,
    input  logic [DATA_W-1:0]    bd_i,

    output logic                 lock_err_o
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_TX   = 2'd1,
        OWN_RX   = 2'd2
    } owner_t;

    owner_t                owner_q, owner_d;
    logic                  last_rx_q;
    logic                  tx_rv_q, rx_rv_q;
    logic [LOCK_MAX_W-1:0] wd_cnt_q, wd_cnt_d;
    logic                  tx_lockout_q, rx_lockout_q;
    logic                  tx_lockout_d, rx_lockout_d;
    logic                  err_q;

    logic                  active;
    logic                  gnt_tx, gnt_rx;
    logic                  tx_lock_eff, rx_lock_eff;
    logic                  wd_fire;

    assign active      = cke_i & rstn_i;
    assign tx_lock_eff = tx_lock_i & ~tx_lockout_q;
    assign rx_lock_eff = rx_lock_i & ~rx_lockout_q;
    assign wd_fire     = (owner_q != OWN_NONE) && (wd_cnt_q == '1);

    // Grant selection: owner is exclusive, otherwise single requester or tie-break
    always_comb begin
        gnt_tx = 1'b0;
        gnt_rx = 1'b0;
        if (active) begin
            case (owner_q)
                OWN_TX:  gnt_tx = tx_req_i;
                OWN_RX:  gnt_rx = rx_req_i;
                default: begin
                    if (tx_req_i && rx_req_i) begin
`ifdef IOB_ETH_BD_ARB_RX_PRIO_EN
                        gnt_rx = 1'b1;
`else
                        if (last_rx_q) gnt_tx = 1'b1;
                        else           gnt_rx = 1'b1;
`endif
                    end else begin
                        gnt_tx = tx_req_i;
                        gnt_rx = rx_req_i;
                    end
                end
            endcase
        end
    end

    // RAM port mux driven from the winning requester; idle drives zeros
    always_comb begin
        bd_en_o   = gnt_tx | gnt_rx;
        bd_wen_o  = 1'b0;
        bd_addr_o = '0;
        bd_o      = '0;
        if (gnt_tx) begin
            bd_wen_o  = tx_wen_i;
            bd_addr_o = tx_addr_i;
            bd_o      = tx_wdata_i;
        end else if (gnt_rx) begin
            bd_wen_o  = rx_wen_i;
            bd_addr_o = rx_addr_i;
            bd_o      = rx_wdata_i;
        end
    end

    // Ownership, watchdog count and lockout next-state
    always_comb begin
        owner_d = owner_q;
        case (owner_q)
            OWN_TX:  if (wd_fire || !tx_lock_eff) owner_d = OWN_NONE;
            OWN_RX:  if (wd_fire || !rx_lock_eff) owner_d = OWN_NONE;
            default: begin
                if (gnt_tx && tx_lock_eff)      owner_d = OWN_TX;
                else if (gnt_rx && rx_lock_eff) owner_d = OWN_RX;
            end
        endcase

        // Count includes the cycle being entered, so it reads all-ones exactly
        // on the last owned cycle; wd_fire forces owner_d to NONE, so no wrap.
        if (owner_d == OWN_NONE)      wd_cnt_d = '0;
        else if (owner_q == OWN_NONE) wd_cnt_d = LOCK_MAX_W'(1);
        else                          wd_cnt_d = wd_cnt_q + LOCK_MAX_W'(1);

        tx_lockout_d = (wd_fire && owner_q == OWN_TX) | (tx_lockout_q & tx_lock_i);
        rx_lockout_d = (wd_fire && owner_q == OWN_RX) | (rx_lockout_q & rx_lock_i);
    end

    // State registers; frozen while cke_i is low
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            owner_q      <= OWN_NONE;
            last_rx_q    <= 1'b1;
            tx_rv_q      <= 1'b0;
            rx_rv_q      <= 1'b0;
            wd_cnt_q     <= '0;
            tx_lockout_q <= 1'b0;
            rx_lockout_q <= 1'b0;
            err_q        <= 1'b0;
        end else if (cke_i) begin
            owner_q      <= owner_d;
            if (gnt_tx || gnt_rx) last_rx_q <= gnt_rx;
            tx_rv_q      <= gnt_tx & ~tx_wen_i;
            rx_rv_q      <= gnt_rx & ~rx_wen_i;
            wd_cnt_q     <= wd_cnt_d;
            tx_lockout_q <= tx_lockout_d;
            rx_lockout_q <= rx_lockout_d;
            err_q        <= (wd_cnt_d == '1);
        end
    end

    assign tx_ack_o    = gnt_tx;
    assign rx_ack_o    = gnt_rx;
    // Registered flags are masked during reset so outputs read idle at once
    assign tx_rvalid_o = tx_rv_q & rstn_i;
    assign rx_rvalid_o = rx_rv_q & rstn_i;
    assign lock_err_o  = err_q & rstn_i;
    assign tx_rdata_o  = bd_i;
    assign rx_rdata_o  = bd_i;

endmodule
